// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction-fetch and load/store ports onto one single-port
// synchronous memory: data priority with a fetch starvation guard, one access in flight.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 12,
    parameter int unsigned MEM_LATENCY     = 1,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    input  logic [ADDR_WIDTH-1:0] if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_rsp_valid,
    output logic [31:0]           if_rsp_data,
    input  logic                  d_req_valid,
    input  logic                  d_req_we,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [31:0]           d_req_wdata,
    output logic                  d_req_ready,
    output logic                  d_rsp_valid,
    output logic [31:0]           d_rsp_data,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DATA_STREAK);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] lat_cnt, lat_cnt_nxt;
    logic [CNT_W-1:0] streak, streak_nxt;
    logic             win_data, win_data_nxt;
    logic             win_we, win_we_nxt;

    // State and transaction-context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            streak   <= '0;
            win_data <= 1'b0;
            win_we   <= 1'b0;
        end else begin
            state    <= state_nxt;
            lat_cnt  <= lat_cnt_nxt;
            streak   <= streak_nxt;
            win_data <= win_data_nxt;
            win_we   <= win_we_nxt;
        end
    end

    // Arbitration, memory strobe and response steering
    always_comb begin
        state_nxt    = state;
        lat_cnt_nxt  = lat_cnt;
        streak_nxt   = streak;
        win_data_nxt = win_data;
        win_we_nxt   = win_we;
        if_req_ready = 1'b0;
        d_req_ready  = 1'b0;
        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        d_rsp_valid  = 1'b0;
        d_rsp_data   = '0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (state)
            IDLE: begin
                // Data wins unless a waiting fetch has already been passed over too often
                if (!rst && d_req_valid && !(if_req_valid && streak == STREAK_MAX)) begin
                    d_req_ready  = 1'b1;
                    mem_en       = 1'b1;
                    mem_we       = d_req_we;
                    mem_addr     = d_req_addr;
                    mem_wdata    = d_req_we ? d_req_wdata : 32'h0;
                    state_nxt    = WAIT;
                    lat_cnt_nxt  = LAT_INIT;
                    win_data_nxt = 1'b1;
                    win_we_nxt   = d_req_we;
                    if (!if_req_valid) begin
                        streak_nxt = '0;
                    end else if (streak != STREAK_MAX) begin
                        streak_nxt = streak + CNT_W'(1);
                    end
                end else if (!rst && if_req_valid) begin
                    if_req_ready = 1'b1;
                    mem_en       = 1'b1;
                    mem_addr     = if_req_addr;
                    state_nxt    = WAIT;
                    lat_cnt_nxt  = LAT_INIT;
                    win_data_nxt = 1'b0;
                    win_we_nxt   = 1'b0;
                    streak_nxt   = '0;
                end
            end
            WAIT: begin
                lat_cnt_nxt = lat_cnt - CNT_W'(1);
                if (lat_cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                    if (!rst) begin
                        if (win_data) begin
                            d_rsp_valid = 1'b1;
                            d_rsp_data  = win_we ? 32'h0 : mem_rdata;
                        end else begin
                            if_rsp_valid = 1'b1;
                            if_rsp_data  = mem_rdata;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == WAIT);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous unified memory between the CPU instruction-fetch port and the load/store data port. It is the first step toward replacing the separate instruction and data memories with one RAM.
- Arbitration: data-priority with a starvation guard for fetch.
- Each accepted request is sequenced through a fixed memory read latency.
- Exactly one response is returned to the winning requester.
- One transaction is in flight at a time.

Parameters:
ADDR_WIDTH, 12, word-address width of the memory (byte address bits [ADDR_WIDTH+1:2]).
MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal range 1..15.
MAX_DATA_STREAK, 4, maximum consecutive data grants while a fetch is waiting; legal range 1..15.

Ports:
clk  in  1  rising-edge clock; the only clock.
rst  in  1  synchronous, active-high reset.
if_req_valid  in  1  fetch request.
if_req_addr  in  ADDR_WIDTH  fetch word address.
if_req_ready  out  1  fetch request accepted this cycle.
if_rsp_valid  out  1  fetch data valid (one-cycle pulse).
if_rsp_data  out  32  fetch instruction word.
d_req_valid  in  1  data request.
d_req_we  in  1  1 = write, 0 = read.
d_req_addr  in  ADDR_WIDTH  data word address.
d_req_wdata  in  32  write data.
d_req_ready  out  1  data request accepted this cycle.
d_rsp_valid  out  1  read data or write acknowledge (one-cycle pulse).
d_rsp_data  out  32  read data; 0 on a write acknowledge.
mem_en  out  1  memory access strobe.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_WIDTH  memory word address.
mem_wdata  out  32  memory write data.
mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after the mem_en cycle.
busy  out  1  transaction in flight (state WAIT).

Behaviour:
- Reset values: state IDLE; streak counter 0; latency counter 0. All ready, rsp_valid, mem_en, mem_we and busy outputs are 0. Data outputs are 0 when idle.
- FSM states: IDLE and WAIT.
- IDLE, no valid requests: all outputs stay 0 and the state stays IDLE.
- IDLE, at least one valid request, at cycle T:
  - Choose a winner (rules below).
  - In the same cycle T, combinationally assert the winner's ready, mem_en=1, mem_addr, and mem_we/mem_wdata (data writes only; otherwise mem_we=0).
  - Register the winner id and the we flag.
  - Go to WAIT with the latency counter set to MEM_LATENCY.
- WAIT:
  - The counter decrements every cycle.
  - When the counter equals 1, at cycle T+MEM_LATENCY:
    - Pulse the winner's rsp_valid.
    - rsp_data = mem_rdata (combinational pass-through) for a read, 0 for a write.
    - Next state is IDLE.
  - No ready is asserted while in WAIT, and mem_en=0.
- Throughput: one transaction per MEM_LATENCY+1 cycles. A new request can be accepted in the cycle after the response.
- Arbitration rules:
  - Only fetch valid: fetch wins.
  - Only data valid: data wins.
  - Both valid: data wins unless streak == MAX_DATA_STREAK, in which case fetch wins.
- Streak counter:
  - Increments on a data grant made while if_req_valid=1.
  - Clears on any fetch grant, or on a data grant made while if_req_valid=0.
  - Saturates at MAX_DATA_STREAK.
- Requester rules:
  - Request fields are sampled only in the ready cycle.
  - A requester may drop valid before ready; nothing is issued for it.
  - Request inputs are ignored during WAIT.
- Never more than one ready high per cycle. Never both rsp_valid outputs high together.
- rst during WAIT: the in-flight transaction is abandoned with no rsp_valid. The next cycle is IDLE with streak 0.
- rst dominates requests in the same cycle: no ready and no mem_en.

Test Plan:
1. MEM_LATENCY=1. Fetch addr 0x004, mem returns 0x00500093.
   -> Cycle T: if_req_ready=1, mem_en=1, mem_addr=0x004. Cycle T+1: if_rsp_valid=1, if_rsp_data=0x00500093. Cycle T+2: busy=0.
2. Fetch and data read (addr 0x010) valid in the same cycle, streak 0.
   -> d_req_ready=1, if_req_ready=0. The fetch is granted in the next IDLE cycle.
3. MAX_DATA_STREAK=2. Fetch and data both held valid continuously.
   -> Grant order: data, data, fetch, data, data, fetch.
4. Data write, addr 0x020, wdata 0xDEADBEEF.
   -> mem_we=1 and mem_wdata=0xDEADBEEF in the accept cycle. d_rsp_valid=1 with d_rsp_data=0 at T+MEM_LATENCY. if_rsp_valid stays 0.
5. MEM_LATENCY=3. Data read accepted at T.
   -> d_rsp_valid only at T+3. Requests at T+1..T+3 get no ready. busy=1 for T+1..T+3.
6. rst asserted at T+1 of a MEM_LATENCY=3 read.
   -> No rsp_valid ever for that read. At T+2, state is IDLE with all outputs 0. A new fetch is accepted at T+2 if valid.
